// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, LU results are buffered and drained in idle slots.
// Optional statistics outputs (stat_conflicts, stat_stalls) are built when RF_ARB_STATS_EN is defined.
module rf_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_reg,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_reg,
  input  logic [31:0] lu_data,
  output logic        wb_stall,
  output logic [31:0] busy,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0] stat_conflicts,
  output logic [15:0] stat_stalls
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;

  typedef enum logic {NORMAL, FORCE} state_t;

  state_t         state;
  logic [SW-1:0]  starve_cnt;
  logic [4:0]     fifo_reg  [DEPTH];
  logic [31:0]    fifo_data [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;

  logic           wb_req;
  logic           wb_grant;
  logic           head_valid;
  logic           head_grant;
  logic           push;
  logic [4:0]     head_reg;
  logic [31:0]    head_data;
  logic [31:0]    busy_next;

  // wb_valid is ignored while stalled; an r0 WB request leaves the slot free for the head.
  assign wb_req     = wb_valid & ~wb_stall;
  assign wb_grant   = wb_req & (wb_reg != 5'd0);
  assign head_valid = (count != '0);
  assign head_grant = head_valid & ~wb_grant;
  assign lu_ready   = (count != CW'(DEPTH));
  assign push       = lu_valid & lu_ready;
  assign head_reg   = fifo_reg[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // A new issue to the same register outranks the retiring write.
  always_comb begin
    busy_next = busy;
    if (head_grant) busy_next[head_reg] = 1'b0;
    if (lu_issue) busy_next[lu_issue_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= lu_reg;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      wb_stall   <= 1'b0;
      RegWrite   <= 1'b0;
      WriteReg   <= 5'd0;
      WriteData  <= 32'd0;
    end else begin
      if (wb_grant) begin
        RegWrite  <= 1'b1;
        WriteReg  <= wb_reg;
        WriteData <= wb_data;
      end else if (head_grant && head_reg != 5'd0) begin
        RegWrite  <= 1'b1;
        WriteReg  <= head_reg;
        WriteData <= head_data;
      end else begin
        RegWrite  <= 1'b0;
      end

      busy  <= busy_next;
      count <= count + CW'(push) - CW'(head_grant);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (head_grant) rd_ptr <= rd_ptr + 1'b1;

      case (state)
        NORMAL: begin
          if (head_valid && !head_grant) begin
            if (starve_cnt == SW'(STARVE_MAX - 1)) begin
              state      <= FORCE;
              wb_stall   <= 1'b1;
              starve_cnt <= '0;
            end else begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        FORCE: begin
          state      <= NORMAL;
          wb_stall   <= 1'b0;
          starve_cnt <= '0;
        end
        default: begin
          state    <= NORMAL;
          wb_stall <= 1'b0;
        end
      endcase
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_conflicts <= 16'd0;
      stat_stalls    <= 16'd0;
    end else begin
      if (wb_req && head_valid && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (state == FORCE && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios then random traffic against a queue-based model.
// Statistics ports are connected and checked when RF_ARB_STATS_EN is defined.
module tb_rf_write_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        lu_issue = 1'b0;
  logic [4:0]  lu_issue_reg = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_reg = '0;
  logic [31:0] lu_data = '0;
  logic        wb_stall;
  logic [31:0] busy;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_conflicts;
  logic [15:0] stat_stalls;
`endif

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_issue(lu_issue), .lu_issue_reg(lu_issue_reg),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .wb_stall(wb_stall), .busy(busy),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
`ifdef RF_ARB_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_stalls(stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int compares = 0;
  int fails    = 0;

  // Reference model: pending LU results as {reg, data}, plus expected outputs.
  logic [36:0] m_q[$];
  logic [31:0] m_busy;
  int          m_wait;
  bit          m_stall;
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  int          m_conf;
  int          m_stl;
  logic [31:0] lu_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_busy  = '0;
    m_wait  = 0;
    m_stall = 1'b0;
    m_rw    = 1'b0;
    m_wr    = '0;
    m_wd    = '0;
    m_conf  = 0;
    m_stl   = 0;
  endtask

  task automatic compare_all();
    check("RegWrite", {31'd0, RegWrite}, {31'd0, m_rw});
    if (m_rw) begin
      check("WriteReg", {27'd0, WriteReg}, {27'd0, m_wr});
      check("WriteData", WriteData, m_wd);
    end
    check("busy", busy, m_busy);
    check("lu_ready", {31'd0, lu_ready}, {31'd0, (m_q.size() < DEPTH)});
    check("wb_stall", {31'd0, wb_stall}, {31'd0, m_stall});
`ifdef RF_ARB_STATS_EN
    check("stat_conflicts", {16'd0, stat_conflicts}, m_conf);
    check("stat_stalls", {16'd0, stat_stalls}, m_stl);
`endif
  endtask

  // One clock: predict from the current model state and inputs, clock, then compare.
  task automatic step();
    bit wb_take, wb_write, head_present, drain, pushing, was_stall;
    logic [36:0] head;
    wb_take      = wb_valid && !m_stall;
    wb_write     = wb_take && (wb_reg != 5'd0);
    head_present = (m_q.size() > 0);
    drain        = head_present && !wb_write;
    pushing      = lu_valid && (m_q.size() < DEPTH);
    head         = head_present ? m_q[0] : 37'd0;
    was_stall    = m_stall;
    @(posedge clk);
    #1;
    if (wb_write) begin
      m_rw = 1'b1; m_wr = wb_reg; m_wd = wb_data;
    end else if (drain && head[36:32] != 5'd0) begin
      m_rw = 1'b1; m_wr = head[36:32]; m_wd = head[31:0];
    end else begin
      m_rw = 1'b0;
    end
    if (drain) m_busy[head[36:32]] = 1'b0;
    if (lu_issue) m_busy[lu_issue_reg] = 1'b1;
    m_busy[0] = 1'b0;
    if (drain) void'(m_q.pop_front());
    if (pushing) m_q.push_back({lu_reg, lu_data});
    if (wb_take && head_present && m_conf < 16'hFFFF) m_conf++;
    if (was_stall && m_stl < 16'hFFFF) m_stl++;
    if (m_stall) begin
      m_stall = 1'b0;
      m_wait  = 0;
    end else if (head_present && !drain) begin
      m_wait++;
      if (m_wait == STARVE_MAX) begin
        m_stall = 1'b1;
        m_wait  = 0;
      end
    end else begin
      m_wait = 0;
    end
    if (RegWrite && WriteReg >= 5'd10 && WriteReg <= 5'd12) lu_log.push_back(WriteData);
    compare_all();
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
    lu_issue = 1'b0; lu_issue_reg = '0;
    lu_valid = 1'b0; lu_reg = '0; lu_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    check("rst_WriteReg", {27'd0, WriteReg}, 32'd0);
    check("rst_WriteData", WriteData, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    check("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    model_clear();
    idle();
    do_reset();

    // WB only
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hA5A5_A5A5;
    step();
    check("t1_RegWrite", {31'd0, RegWrite}, 32'd1);
    check("t1_WriteReg", {27'd0, WriteReg}, 32'd5);
    check("t1_WriteData", WriteData, 32'hA5A5_A5A5);
    idle();
    step();

    // LU result drained in an idle slot
    lu_issue = 1'b1; lu_issue_reg = 5'd9;
    step();
    check("t2_busy9_set", {31'd0, busy[9]}, 32'd1);
    idle();
    lu_valid = 1'b1; lu_reg = 5'd9; lu_data = 32'h1234;
    step();
    idle();
    step();
    check("t2_RegWrite", {31'd0, RegWrite}, 32'd1);
    check("t2_WriteReg", {27'd0, WriteReg}, 32'd9);
    check("t2_WriteData", WriteData, 32'h1234);
    check("t2_busy9_clr", {31'd0, busy[9]}, 32'd0);

    // Starvation forces one WB stall cycle
    wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h1111;
    lu_valid = 1'b1; lu_reg = 5'd7; lu_data = 32'h7777;
    step();
    lu_valid = 1'b0;
    for (int i = 1; i <= STARVE_MAX; i++) begin
      step();
      check("t3_stall_wait", {31'd0, wb_stall}, {31'd0, (i == STARVE_MAX)});
    end
    step();
    check("t3_force_RegWrite", {31'd0, RegWrite}, 32'd1);
    check("t3_force_WriteReg", {27'd0, WriteReg}, 32'd7);
    check("t3_force_WriteData", WriteData, 32'h7777);
    check("t3_stall_release", {31'd0, wb_stall}, 32'd0);
    step();
    check("t3_wb_resume", {27'd0, WriteReg}, 32'd1);
    idle();
    step();

    // FIFO full back-pressure and ordering
    lu_log.delete();
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h2222;
    lu_valid = 1'b1; lu_reg = 5'd10; lu_data = 32'hA0;
    step();
    lu_reg = 5'd11; lu_data = 32'hB0;
    step();
    check("t4_full", {31'd0, lu_ready}, 32'd0);
    lu_reg = 5'd12; lu_data = 32'hC0;
    begin
      bit accepted;
      accepted = 1'b0;
      for (int i = 0; i < 20 && !accepted; i++) begin
        accepted = (m_q.size() < DEPTH);
        step();
      end
      check("t4_third_accepted", {31'd0, accepted}, 32'd1);
    end
    idle();
    for (int i = 0; i < 4; i++) step();
    check("t4_count", lu_log.size(), 32'd3);
    if (lu_log.size() == 3) begin
      check("t4_order0", lu_log[0], 32'hA0);
      check("t4_order1", lu_log[1], 32'hB0);
      check("t4_order2", lu_log[2], 32'hC0);
    end

    // Register 0 handling
    do_reset();
    wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h44;
    lu_valid = 1'b1; lu_reg = 5'd3; lu_data = 32'h33;
    lu_issue = 1'b1; lu_issue_reg = 5'd0;
    step();
    check("t5_busy_r0", busy, 32'd0);
    idle();
    wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h55;
    step();
    check("t5_RegWrite", {31'd0, RegWrite}, 32'd1);
    check("t5_WriteReg", {27'd0, WriteReg}, 32'd3);
    check("t5_WriteData", WriteData, 32'h33);
    idle();
    step();

    // Reset with a full FIFO and busy bits set
    wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h2;
    lu_issue = 1'b1; lu_issue_reg = 5'd9;
    step();
    lu_issue_reg = 5'd10;
    lu_valid = 1'b1; lu_reg = 5'd20; lu_data = 32'h20;
    step();
    lu_issue = 1'b0;
    lu_reg = 5'd21; lu_data = 32'h21;
    step();
    check("t6_busy_pre", busy, 32'h0000_0600);
    check("t6_full_pre", {31'd0, lu_ready}, 32'd0);
    idle();
    do_reset();
    step();
    check("t6_no_write_after", {31'd0, RegWrite}, 32'd0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        wb_valid     = ($urandom_range(0, 3) != 0);
        wb_reg       = 5'($urandom_range(0, 31));
        wb_data      = $urandom;
        lu_issue     = ($urandom_range(0, 2) == 0);
        lu_issue_reg = 5'($urandom_range(0, 31));
        lu_valid     = ($urandom_range(0, 1) == 0);
        lu_reg       = 5'($urandom_range(0, 31));
        lu_data      = $urandom;
        step();
      end
    end
    idle();
    for (int i = 0; i < 8; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
